// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order write-back FIFO feeding the register file write port,
// with pending-write hazard detection and youngest-entry forwarding for two read ports.
module reg_wb_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_dest,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              wb_stall,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    input  logic [ADDR_W-1:0] chk_addr_1,
    output logic              pend_1,
    output logic [DATA_W-1:0] fwd_data_1,
    input  logic [ADDR_W-1:0] chk_addr_2,
    output logic              pend_2,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic [$clog2(DEPTH):0] q_count,
    output logic              q_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, idx;
    logic [CW-1:0]     count;
    logic              push, pop;
    logic [ADDR_W-1:0] push_dest;
    logic [DATA_W-1:0] push_data;

    assign ld_ready       = rst_n && (count < CW'(DEPTH));
    assign alu_ready      = ld_ready && !ld_valid;
    assign push_dest      = ld_valid ? ld_dest : alu_dest;
    assign push_data      = ld_valid ? ld_data : alu_data;
    // r0 writes complete the handshake but are dropped
    assign push           = ((ld_valid && ld_ready) || (alu_valid && alu_ready)) && push_dest != '0;
    assign q_count        = count;
    assign q_empty        = count == '0;
    assign reg_write_en   = !q_empty && !wb_stall;
    assign pop            = reg_write_en;
    assign reg_write_dest = reg_write_en ? dest_q[rd_ptr] : '0;
    assign reg_write_data = reg_write_en ? data_q[rd_ptr] : '0;

    // scan oldest to youngest so the last match wins
    always_comb begin
        pend_1     = 1'b0;
        fwd_data_1 = '0;
        pend_2     = 1'b0;
        fwd_data_2 = '0;
        idx        = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count && chk_addr_1 != '0 && dest_q[idx] == chk_addr_1) begin
                pend_1     = 1'b1;
                fwd_data_1 = data_q[idx];
            end
            if (CW'(i) < count && chk_addr_2 != '0 && dest_q[idx] == chk_addr_2) begin
                pend_2     = 1'b1;
                fwd_data_2 = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                dest_q[wr_ptr] <= push_dest;
                data_q[wr_ptr] <= push_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue: randomized and directed scoreboard bench for reg_wb_queue
// against a queue-based reference of pending register writes.
module tb_reg_wb_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0]  d;
        logic [15:0] v;
    } wr_t;

    logic        clk = 0, rst_n = 0;
    logic        alu_valid = 0, ld_valid = 0, wb_stall = 0;
    logic [2:0]  alu_dest = 0, ld_dest = 0, chk_addr_1 = 0, chk_addr_2 = 0;
    logic [15:0] alu_data = 0, ld_data = 0;
    logic        alu_ready, ld_ready, reg_write_en, pend_1, pend_2, q_empty;
    logic [2:0]  reg_write_dest, q_count;
    logic [15:0] reg_write_data, fwd_data_1, fwd_data_2;

    wr_t exp_q[$];
    int  popped = 0;
    int  checks = 0, errors = 0;

    reg_wb_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
        .wb_stall(wb_stall),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
        .chk_addr_1(chk_addr_1), .pend_1(pend_1), .fwd_data_1(fwd_data_1),
        .chk_addr_2(chk_addr_2), .pend_2(pend_2), .fwd_data_2(fwd_data_2),
        .q_count(q_count), .q_empty(q_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected write recorded when the edge accepts it
    always @(posedge clk) begin
        if (rst_n && exp_q.size() + popped < DEPTH) begin
            if (ld_valid) begin
                if (ld_dest != 0) exp_q.push_back('{ld_dest, ld_data});
            end else if (alu_valid && alu_dest != 0) begin
                exp_q.push_back('{alu_dest, alu_data});
            end
        end
    end

    always @(negedge clk) begin
        int          sz;
        logic        e_we, p1, p2;
        logic [15:0] f1, f2;
        sz   = exp_q.size();
        e_we = rst_n && sz > 0 && !wb_stall;
        p1 = 0; p2 = 0; f1 = 0; f2 = 0;
        for (int i = sz - 1; i >= 0; i--) begin
            if (!p1 && chk_addr_1 != 0 && exp_q[i].d == chk_addr_1) begin p1 = 1; f1 = exp_q[i].v; end
            if (!p2 && chk_addr_2 != 0 && exp_q[i].d == chk_addr_2) begin p2 = 1; f2 = exp_q[i].v; end
        end
        chk("ld_ready", ld_ready, rst_n && sz < DEPTH);
        chk("alu_ready", alu_ready, rst_n && sz < DEPTH && !ld_valid);
        chk("q_count", q_count, sz);
        chk("q_empty", q_empty, sz == 0);
        chk("write_en", reg_write_en, e_we);
        chk("pend_1", pend_1, p1);
        chk("fwd_data_1", fwd_data_1, f1);
        chk("pend_2", pend_2, p2);
        chk("fwd_data_2", fwd_data_2, f2);
        if (e_we) begin
            chk("write_dest", reg_write_dest, exp_q[0].d);
            chk("write_data", reg_write_data, exp_q[0].v);
            void'(exp_q.pop_front());
        end else begin
            chk("idle_dest", reg_write_dest, 0);
            chk("idle_data", reg_write_data, 0);
        end
        popped = e_we ? 1 : 0;
    end

    task automatic drive(input logic lv, input logic [2:0] ld, input logic [15:0] lda,
                         input logic av, input logic [2:0] ad, input logic [15:0] ada,
                         input logic st);
        @(posedge clk);
        #1;
        ld_valid = lv; ld_dest = ld; ld_data = lda;
        alu_valid = av; alu_dest = ad; alu_data = ada;
        wb_stall = st;
    endtask

    task automatic idle(input int n, input logic st);
        repeat (n) drive(0, 0, 0, 0, 0, 0, st);
    endtask

    initial begin
        idle(2, 0);
        rst_n = 1;
        idle(1, 0);
        drive(0, 0, 0, 1, 3, 16'h1234, 0);
        idle(3, 0);
        for (int i = 1; i <= 5; i++) drive(1, 3'(i), 16'(16'h0100 + i), 1, 7, 16'hDEAD, 1);
        idle(6, 0);
        chk_addr_1 = 0;
        drive(1, 0, 16'hFFFF, 0, 0, 0, 0);
        idle(2, 0);
        chk_addr_2 = 5;
        drive(1, 5, 16'h0001, 0, 0, 0, 1);
        drive(1, 5, 16'h0002, 0, 0, 0, 1);
        idle(2, 1);
        idle(4, 0);
        for (int i = 0; i <= 10; i++) drive(0, 0, 0, 1, 3'(i % 7 + 1), 16'(16'hA000 + i), 0);
        idle(3, 0);
        for (int i = 1; i <= 3; i++) drive(0, 0, 0, 1, 3'(i), 16'(16'hC000 + i), 1);
        @(posedge clk);
        #1;
        alu_valid = 0;
        wb_stall = 0;
        #1;
        chk("pre_rst_count", q_count, 3);
        rst_n = 0;
        exp_q.delete();
        popped = 0;
        #1;
        chk("rst_async_count", q_count, 0);
        chk("rst_async_we", reg_write_en, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        chk("post_rst_ld_ready", ld_ready, 1);
        chk("post_rst_alu_ready", alu_ready, 1);
        repeat (400) begin
            chk_addr_1 = 3'($urandom_range(0, 7));
            chk_addr_2 = 3'($urandom_range(0, 7));
            drive($urandom_range(0, 2) == 0, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 3) == 0);
        end
        idle(8, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
